// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU with valid/ready handshakes: one-cycle ADD/SUB/logic, iterative MUL/DIV/MOD.
// Optional saturation of ADD/SUB results is enabled by defining ULA_SAT_EN.
module ula_multiciclo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ula_operation,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [3:0] OP_ADD = 4'b0001, OP_SUB = 4'b0010, OP_MUL = 4'b0011,
                           OP_DIV = 4'b0100, OP_MOD = 4'b0101, OP_AND = 4'b0110,
                           OP_OR  = 4'b0111, OP_XOR = 4'b1000, OP_NOT = 4'b1001,
                           OP_NOR = 4'b1010, OP_NAND = 4'b1011, OP_XNOR = 4'b1100;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] m_q, m_d, acc_q, acc_d, lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d;
    logic [3:0]       flags_q, flags_d;
    logic             dbz_q, dbz_d;

    // Single-cycle datapath, evaluated on the live operands at accept time
    logic [WIDTH:0]   add_w, sub_w;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_v, sc_dbz, sc_inv;

    always_comb begin
        add_w  = {1'b0, operand1} + {1'b0, operand2};
        sub_w  = {1'b0, operand1} - {1'b0, operand2};
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_dbz = 1'b0;
        sc_inv = 1'b0;
        case (ula_operation)
            OP_ADD: begin
                sc_res = add_w[WIDTH-1:0];
                sc_c   = add_w[WIDTH];
                sc_v   = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                         (add_w[WIDTH-1] != operand1[WIDTH-1]);
`ifdef ULA_SAT_EN
                if (add_w[WIDTH]) sc_res = '1;
`endif
            end
            OP_SUB: begin
                sc_res = sub_w[WIDTH-1:0];
                sc_c   = sub_w[WIDTH];
                sc_v   = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                         (sub_w[WIDTH-1] != operand1[WIDTH-1]);
`ifdef ULA_SAT_EN
                if (sub_w[WIDTH]) sc_res = '0;
`endif
            end
            // Only reached here with a zero divisor
            OP_DIV:  begin sc_res = '1;       sc_dbz = 1'b1; end
            OP_MOD:  begin sc_res = operand1; sc_dbz = 1'b1; end
            OP_AND:  sc_res = operand1 & operand2;
            OP_OR:   sc_res = operand1 | operand2;
            OP_XOR:  sc_res = operand1 ^ operand2;
            OP_NOT:  sc_res = ~operand1;
            OP_NOR:  sc_res = ~(operand1 | operand2);
            OP_NAND: sc_res = ~(operand1 & operand2);
            OP_XNOR: sc_res = ~(operand1 ^ operand2);
            default: sc_inv = 1'b1;
        endcase
    end

    // One iteration step: shift-add for MUL ({acc,lo} = partial product),
    // restoring division for DIV/MOD (acc = remainder, lo = dividend/quotient)
    logic [WIDTH:0]   mul_sum, div_sh, div_tr;
    logic [WIDTH-1:0] mul_acc, mul_lo, div_rem, div_quo;

    always_comb begin
        mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        mul_acc = mul_sum[WIDTH:1];
        mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
        div_sh  = {acc_q, lo_q[WIDTH-1]};
        div_tr  = div_sh - {1'b0, m_q};
        if (!div_tr[WIDTH]) begin
            div_rem = div_tr[WIDTH-1:0];
            div_quo = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            div_rem = div_sh[WIDTH-1:0];
            div_quo = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    logic             is_mul;
    logic [WIDTH-1:0] fin_res;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        m_d     = m_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        hi_d    = hi_q;
        flags_d = flags_q;
        dbz_d   = dbz_q;
        is_mul  = (op_q == OP_MUL);
        fin_res = is_mul ? mul_lo : ((op_q == OP_DIV) ? div_quo : div_rem);
        case (state_q)
            IDLE: if (in_valid) begin
                op_d = ula_operation;
                if (ula_operation == OP_MUL) begin
                    m_d     = operand1;
                    acc_d   = '0;
                    lo_d    = operand2;
                    cnt_d   = CW'(WIDTH);
                    state_d = EXEC;
                end else if ((ula_operation == OP_DIV || ula_operation == OP_MOD) &&
                             operand2 != '0) begin
                    m_d     = operand2;
                    acc_d   = '0;
                    lo_d    = operand1;
                    cnt_d   = CW'(WIDTH);
                    state_d = EXEC;
                end else begin
                    res_d   = sc_res;
                    hi_d    = '0;
                    flags_d = sc_inv ? 4'b0000
                                     : {sc_v, sc_c, sc_res[WIDTH-1], sc_res == '0};
                    dbz_d   = sc_dbz;
                    state_d = DONE;
                end
            end
            EXEC: begin
                cnt_d = cnt_q - CW'(1);
                acc_d = is_mul ? mul_acc : div_rem;
                lo_d  = is_mul ? mul_lo  : div_quo;
                if (cnt_q == CW'(1)) begin
                    res_d   = fin_res;
                    hi_d    = is_mul ? mul_acc : '0;
                    flags_d = {is_mul && (mul_acc != '0), is_mul && (mul_acc != '0),
                               fin_res[WIDTH-1], fin_res == '0};
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            flags_q <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            flags_q <= flags_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign result      = res_q;
    assign result_hi   = hi_q;
    assign flags       = flags_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed + random bench for ula_multiciclo (WIDTH=8) with a queue-based scoreboard.
module tb_ula_multiciclo;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   ula_operation = 4'h0;
    logic [W-1:0] operand1 = '0, operand2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result, result_hi;
    logic [3:0]   flags;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] hi;
        logic [3:0]   f;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t sb[$];

    ula_multiciclo #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ula_operation(ula_operation), .operand1(operand1), .operand2(operand2),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .result_hi(result_hi), .flags(flags), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Reference model: flags as {V,C,S,Z}
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W:0]     s;
        logic [2*W-1:0] p;
        logic [W-1:0]   r;
        logic c, v, inv;
        e.hi = '0; e.dbz = 1'b0; e.lat = 1;
        r = '0; c = 1'b0; v = 1'b0; inv = 1'b0;
        case (op)
            4'd1: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0]; c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
`ifdef ULA_SAT_EN
                if (c) r = '1;
`endif
            end
            4'd2: begin
                r = a - b; c = (a < b);
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
`ifdef ULA_SAT_EN
                if (c) r = '0;
`endif
            end
            4'd3: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                r = p[W-1:0]; e.hi = p[2*W-1:W];
                c = (e.hi != 0); v = c; e.lat = W + 1;
            end
            4'd4: if (b == 0) begin r = '1; e.dbz = 1'b1; end
                  else begin r = a / b; e.lat = W + 1; end
            4'd5: if (b == 0) begin r = a; e.dbz = 1'b1; end
                  else begin r = a % b; e.lat = W + 1; end
            4'd6:  r = a & b;
            4'd7:  r = a | b;
            4'd8:  r = a ^ b;
            4'd9:  r = ~a;
            4'd10: r = ~(a | b);
            4'd11: r = ~(a & b);
            4'd12: r = ~(a ^ b);
            default: inv = 1'b1;
        endcase
        e.r = r;
        e.f = inv ? 4'b0000 : {v, c, r[W-1], r == 0};
        return e;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push);
        @(negedge clk);
        ula_operation = op; operand1 = a; operand2 = b; in_valid = 1'b1;
        chk("in_ready_at_issue", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Garbage while busy must be ignored
        ula_operation = 4'($urandom); operand1 = W'($urandom); operand2 = W'($urandom);
        if (push) sb.push_back(model(op, a, b));
    endtask

    task automatic collect(input int hold);
        exp_t e;
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 40);
        e = sb.pop_front();
        chk("latency", n, e.lat);
        for (int k = 0; k <= hold; k++) begin
            if (k > 0) begin
                @(negedge clk);
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_in_ready", in_ready, 1'b0);
            end
            chk("result", result, e.r);
            chk("result_hi", result_hi, e.hi);
            chk("flags", flags, e.f);
            chk("div_by_zero", div_by_zero, e.dbz);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_pop", {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        int seen;
        logic [3:0] rop;
        logic [W-1:0] ra, rb;

        @(negedge clk);
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_outputs", {result, result_hi, flags, div_by_zero}, '0);
        rst_n = 1'b1;

        issue(4'd1, 8'h7F, 8'h01, 1'b1); collect(0);
        issue(4'd2, 8'h05, 8'h07, 1'b1); collect(0);
        issue(4'd3, 8'h10, 8'h10, 1'b1); collect(0);
        issue(4'd4, 8'h64, 8'h07, 1'b1); collect(0);
        issue(4'd5, 8'h64, 8'h07, 1'b1); collect(0);
        issue(4'd4, 8'h2A, 8'h00, 1'b1); collect(0);
        issue(4'd5, 8'h2A, 8'h00, 1'b1); collect(0);
        issue(4'd3, 8'hFF, 8'hFF, 1'b1); collect(0);
        issue(4'd9, 8'h5A, 8'h00, 1'b1); collect(0);
        issue(4'd11, 8'hF0, 8'h3C, 1'b1); collect(0);
        issue(4'd15, 8'h12, 8'h34, 1'b1); collect(0);
        issue(4'd0, 8'h00, 8'h00, 1'b1); collect(0);
        issue(4'd8, 8'hF0, 8'h0F, 1'b1); collect(5);
`ifdef ULA_SAT_EN
        issue(4'd1, 8'hFF, 8'h02, 1'b1); collect(0);
        issue(4'd2, 8'h05, 8'h07, 1'b1); collect(0);
`endif

        // Reset in the middle of a multiply: the operation is dropped
        issue(4'd3, 8'hFF, 8'hFF, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", out_valid, 1'b0);
        chk("rst_mid_outputs", {result, result_hi, flags, div_by_zero}, '0);
        chk("rst_mid_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rst_no_valid", seen, 0);
        issue(4'd1, 8'h01, 8'h01, 1'b1); collect(0);

        for (int i = 0; i < 12; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = W'($urandom);
            rb  = (i % 4 == 3) ? '0 : W'($urandom);
            issue(rop, ra, rb, 1'b1);
            collect(i % 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end
endmodule
